// File: rtl/dcs_frame_encoder.sv
// dcs_frame_encoder: serial payload shift-in, CRC append, rate-1/2 K=3 convolutional encode.
// Define DCS_TAIL_FLUSH_EN to encode two zero tail bits so the trellis ends in state 0.
module dcs_frame_encoder #(
  parameter int               DATA_W   = 32,
  parameter int               CRC_W    = 16,
  parameter logic [CRC_W-1:0] CRC_POLY = 16'h1021,
  parameter logic [CRC_W-1:0] CRC_INIT = 16'h0000,
  parameter logic [2:0]       G0       = 3'b111,
  parameter logic [2:0]       G1       = 3'b101,
  localparam int              FW       = DATA_W + CRC_W,
`ifdef DCS_TAIL_FLUSH_EN
  localparam int              TAIL_W   = 2,
`else
  localparam int              TAIL_W   = 0,
`endif
  localparam int              ENC_W    = FW + TAIL_W,
  localparam int              OUT_W    = 2 * ENC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             d,
  output logic             busy,
  output logic [CRC_W-1:0] crc_out,
  output logic             done,
  output logic [OUT_W-1:0] final_ans
);

  localparam int CNT_W = $clog2(FW + 3);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_ENCODE
  } state_t;

  state_t             r_state;
  state_t             w_state_next;

  logic [CNT_W-1:0]   r_cnt;
  logic [DATA_W-1:0]  r_payload;
  logic [CRC_W-1:0]   r_crc;
  logic [ENC_W-1:0]   r_frame;
  logic               r_s1;
  logic               r_s2;
  logic [OUT_W-1:0]   r_shadow;
  logic [OUT_W-1:0]   r_final;
  logic               r_done;

  logic               w_last_shift;
  logic               w_last_enc;
  logic               w_fb;
  logic [CRC_W-1:0]   w_crc_next;
  logic [DATA_W-1:0]  w_payload_next;
  logic [FW-1:0]      w_frame_raw;
  logic [ENC_W-1:0]   w_frame_init;
  logic               w_bit;
  logic [2:0]         w_taps;
  logic [1:0]         w_pair;
  logic [OUT_W-1:0]   w_shadow_next;

  assign w_last_shift   = (r_cnt == CNT_W'(DATA_W - 1));
  assign w_last_enc     = (r_cnt == CNT_W'(ENC_W - 1));

  // Non-reflected CRC: feedback is the incoming bit against the register MSB.
  assign w_fb           = d ^ r_crc[CRC_W-1];
  assign w_crc_next     = (r_crc << 1) ^ (w_fb ? CRC_POLY : '0);
  assign w_payload_next = (r_payload << 1) | DATA_W'(d);

  // Tail bits (if any) are the zeros shifted in below the CRC.
  assign w_frame_raw    = {w_payload_next, w_crc_next};
  assign w_frame_init   = ENC_W'(w_frame_raw) << TAIL_W;

  assign w_bit          = r_frame[ENC_W-1];
  assign w_taps         = {w_bit, r_s1, r_s2};
  assign w_pair         = {^(G0 & w_taps), ^(G1 & w_taps)};
  assign w_shadow_next  = {r_shadow[OUT_W-3:0], w_pair};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        busy = 1'b1;
        if (w_last_shift) begin
          w_state_next = ST_ENCODE;
        end
      end
      ST_ENCODE: begin
        busy = 1'b1;
        if (w_last_enc) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_payload <= '0;
      r_crc     <= CRC_INIT;
      r_frame   <= '0;
      r_s1      <= 1'b0;
      r_s2      <= 1'b0;
      r_shadow  <= '0;
      r_final   <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_crc <= CRC_INIT;
            r_cnt <= '0;
            r_s1  <= 1'b0;
            r_s2  <= 1'b0;
          end
        end
        ST_SHIFT: begin
          r_payload <= w_payload_next;
          r_crc     <= w_crc_next;
          if (w_last_shift) begin
            r_cnt   <= '0;
            r_frame <= w_frame_init;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_ENCODE: begin
          r_frame  <= r_frame << 1;
          r_s1     <= w_bit;
          r_s2     <= r_s1;
          r_shadow <= w_shadow_next;
          if (w_last_enc) begin
            r_cnt   <= '0;
            r_final <= w_shadow_next;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  assign crc_out   = r_crc;
  assign done      = r_done;
  assign final_ans = r_final;

endmodule

// File: tb/tb_dcs_frame_encoder.sv
// Self-checking bench for dcs_frame_encoder against a polynomial-division CRC and bit-list
// convolutional reference model. Define DCS_TAIL_FLUSH_EN to exercise the 8/8 tail-flush build.
module tb_dcs_frame_encoder;

`ifdef DCS_TAIL_FLUSH_EN
  localparam int                 P_DATA_W  = 8;
  localparam int                 P_CRC_W   = 8;
  localparam int                 P_TAIL    = 2;
  localparam logic [P_CRC_W-1:0] P_POLY    = 8'h07;
  localparam logic [P_CRC_W-1:0] P_ONE_CRC = 8'h07;
`else
  localparam int                 P_DATA_W  = 32;
  localparam int                 P_CRC_W   = 16;
  localparam int                 P_TAIL    = 0;
  localparam logic [P_CRC_W-1:0] P_POLY    = 16'h1021;
  localparam logic [P_CRC_W-1:0] P_ONE_CRC = 16'h1021;
`endif
  localparam logic [P_CRC_W-1:0] P_INIT    = '0;
  localparam logic [2:0]         M_G0      = 3'b111;
  localparam logic [2:0]         M_G1      = 3'b101;
  localparam int P_FW    = P_DATA_W + P_CRC_W;
  localparam int P_ENC_W = P_FW + P_TAIL;
  localparam int P_OUT_W = 2 * P_ENC_W;
  localparam int P_LAT   = P_DATA_W + P_ENC_W;
  localparam int P_ABORT = (P_DATA_W > 20) ? 20 : (P_DATA_W / 2);

  logic               clk;
  logic               rst;
  logic               start;
  logic               d;
  logic               busy;
  logic [P_CRC_W-1:0] crc_out;
  logic               done;
  logic [P_OUT_W-1:0] final_ans;

  int errors = 0;
  int checks = 0;

  dcs_frame_encoder #(
    .DATA_W   (P_DATA_W),
    .CRC_W    (P_CRC_W),
    .CRC_POLY (P_POLY),
    .CRC_INIT (P_INIT),
    .G0       (M_G0),
    .G1       (M_G1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .d         (d),
    .busy      (busy),
    .crc_out   (crc_out),
    .done      (done),
    .final_ans (final_ans)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mask_payload(input logic [63:0] p);
    return p & ((64'd1 << P_DATA_W) - 64'd1);
  endfunction

  // CRC as remainder of payload * x^CRC_W divided by the generator (init is zero).
  function automatic logic [127:0] model_crc(input logic [63:0] p);
    logic [127:0] m;
    logic [127:0] g;
    m = 128'(mask_payload(p)) << P_CRC_W;
    g = (128'd1 << P_CRC_W) | 128'(P_POLY);
    for (int i = P_FW - 1; i >= P_CRC_W; i--) begin
      if (m[i]) m = m ^ (g << (i - P_CRC_W));
    end
    return m & ((128'd1 << P_CRC_W) - 128'd1);
  endfunction

  function automatic logic [127:0] model_word(input logic [63:0] p);
    logic [127:0] fv;
    logic [127:0] w;
    bit           f[$];
    bit           b, s1, s2, c0, c1;
    fv = ((128'(mask_payload(p)) << P_CRC_W) | model_crc(p)) << P_TAIL;
    for (int k = 0; k < P_ENC_W; k++) f.push_back(fv[P_ENC_W - 1 - k]);
    w = '0;
    for (int k = 0; k < P_ENC_W; k++) begin
      b  = f[k];
      s1 = (k >= 1) ? f[k-1] : 1'b0;
      s2 = (k >= 2) ? f[k-2] : 1'b0;
      c0 = (M_G0[2] & b) ^ (M_G0[1] & s1) ^ (M_G0[0] & s2);
      c1 = (M_G1[2] & b) ^ (M_G1[1] & s1) ^ (M_G1[0] & s2);
      w  = (w << 2) | {126'd0, c0, c1};
    end
    return w;
  endfunction

  // Starts a frame, optionally pulses start again during SHIFT, and checks the whole transaction.
  task automatic run_frame(input string tag, input logic [63:0] p, input int glitch_at);
    int edges;
    int busy_cnt;
    logic [127:0] exp_word;
    exp_word = model_word(p);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    edges    = 0;
    busy_cnt = 0;
    for (int i = 0; i < P_DATA_W; i++) begin
      d     = p[P_DATA_W - 1 - i];
      start = (i == glitch_at);
      if (busy === 1'b1) busy_cnt++;
      @(posedge clk);
      #1;
      edges++;
    end
    start = 1'b0;
    d     = 1'($urandom);
    while (done !== 1'b1 && edges < P_LAT + 20) begin
      if (busy === 1'b1) busy_cnt++;
      @(posedge clk);
      #1;
      edges++;
    end
    $display("frame %s payload=%0h crc=%0h word=%0h edges=%0d", tag, mask_payload(p), crc_out, final_ans, edges);
    check({tag, "_latency"}, 128'(edges), 128'(P_LAT));
    check({tag, "_busy_cycles"}, 128'(busy_cnt), 128'(P_LAT));
    check({tag, "_busy_at_done"}, 128'(busy), 128'd0);
    check({tag, "_crc"}, 128'(crc_out), model_crc(p));
    check({tag, "_word"}, 128'(final_ans), exp_word);
    @(posedge clk);
    #1;
    check({tag, "_done_width"}, 128'(done), 128'd0);
    check({tag, "_word_hold"}, 128'(final_ans), exp_word);
  endtask

  initial begin
    logic [63:0]  pa;
    logic [63:0]  pb;
    logic [127:0] wa;
    int           edges;
    bit           stable;

    rst   = 1'b1;
    start = 1'b0;
    d     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 128'(busy), 128'd0);
    check("reset_done", 128'(done), 128'd0);
    check("reset_crc", 128'(crc_out), 128'(P_INIT));
    check("reset_word", 128'(final_ans), 128'd0);
    rst = 1'b0;

    // T1: all-zero payload
    run_frame("T1", 64'd0, -1);
    check("T1_word_zero", 128'(final_ans), 128'd0);

    // T2: payload 1
    run_frame("T2", 64'd1, -1);
    check("T2_crc_const", 128'(crc_out), 128'(P_ONE_CRC));
`ifndef DCS_TAIL_FLUSH_EN
    check("T2_upper_zero", 128'(final_ans) >> 34, 128'd0);
`endif

    // T3: fixed payload with a start pulse mid-SHIFT
    run_frame("T3", 64'h0301_0203, P_DATA_W / 2);

    for (int n = 0; n < 4; n++) begin
      run_frame("RND", {32'($urandom), 32'($urandom)}, int'($urandom_range(0, P_DATA_W - 1)));
    end

    // T4: reset during SHIFT, then a clean frame
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < P_ABORT - 1; i++) begin
      d = 1'($urandom);
      @(posedge clk);
      #1;
    end
    rst   = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    check("T4_busy", 128'(busy), 128'd0);
    check("T4_done", 128'(done), 128'd0);
    check("T4_crc", 128'(crc_out), 128'(P_INIT));
    check("T4_word", 128'(final_ans), 128'd0);
    rst   = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;
    check("T4_idle", 128'(busy), 128'd0);
    $display("frame T4 aborted at shift edge %0d", P_ABORT);
    run_frame("T4b", 64'd1, -1);
    check("T4b_crc_const", 128'(crc_out), 128'(P_ONE_CRC));

    // T5: start held high through done for back-to-back frames
    pa = {32'($urandom), 32'($urandom)};
    pb = {32'($urandom), 32'($urandom)};
    wa = model_word(pa);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    edges = 0;
    for (int i = 0; i < P_DATA_W; i++) begin
      d = pa[P_DATA_W - 1 - i];
      @(posedge clk);
      #1;
      edges++;
    end
    while (done !== 1'b1 && edges < P_LAT + 20) begin
      @(posedge clk);
      #1;
      edges++;
    end
    $display("frame T5a payload=%0h word=%0h edges=%0d", mask_payload(pa), final_ans, edges);
    check("T5a_latency", 128'(edges), 128'(P_LAT));
    check("T5a_word", 128'(final_ans), wa);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("T5_restart_busy", 128'(busy), 128'd1);
    check("T5_restart_done", 128'(done), 128'd0);
    stable = 1'b1;
    edges  = 0;
    for (int i = 0; i < P_DATA_W; i++) begin
      d = pb[P_DATA_W - 1 - i];
      if (final_ans !== wa[P_OUT_W-1:0]) stable = 1'b0;
      @(posedge clk);
      #1;
      edges++;
    end
    while (done !== 1'b1 && edges < P_LAT + 20) begin
      if (final_ans !== wa[P_OUT_W-1:0]) stable = 1'b0;
      @(posedge clk);
      #1;
      edges++;
    end
    $display("frame T5b payload=%0h word=%0h edges=%0d", mask_payload(pb), final_ans, edges);
    check("T5a_word_stable", 128'(stable), 128'd1);
    check("T5b_latency", 128'(edges), 128'(P_LAT));
    check("T5b_crc", 128'(crc_out), model_crc(pb));
    check("T5b_word", 128'(final_ans), model_word(pb));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
